// File: rtl/qix_crtc.sv
`default_nettype none
// ============================================================================
//  Module   : qix_crtc
//  Purpose  : 6845-style CRT timing generator for the Qix video board, with
//             a VSync FIRQ to the Data CPU that holds until acknowledged.
//  Revision : 1.0 - initial release
// ============================================================================
module qix_crtc #(
   parameter int         PIX_DIV = 4,
   parameter int         CHAR_W  = 8,
   parameter int         MA_W    = 14,
   parameter int         RA_W    = 5,
   parameter logic [7:0] R0_DEF  = 8'd39,
   parameter logic [7:0] R1_DEF  = 8'd32,
   parameter logic [7:0] R2_DEF  = 8'd34,
   parameter logic [7:0] R3_DEF  = 8'h24,
   parameter logic [7:0] R4_DEF  = 8'd32,
   parameter logic [7:0] R6_DEF  = 8'd32,
   parameter logic [7:0] R7_DEF  = 8'd32,
   parameter logic [7:0] R9_DEF  = 8'd7,
   parameter logic [7:0] R12_DEF = 8'd0,
   parameter logic [7:0] R13_DEF = 8'd0
) (
   input  logic            clk_20m,
   input  logic            reset_n,
   input  logic            reg_cs,
   input  logic            reg_rs,
   input  logic            reg_we,
   input  logic [7:0]      reg_din,
   output logic [7:0]      reg_dout,
   input  logic            firq_ack,
   output logic            ce_pix,
   output logic            ce_char,
   output logic            hsync,
   output logic            vsync,
   output logic            hblank,
   output logic            vblank,
   output logic            de,
   output logic [MA_W-1:0] ma,
   output logic [RA_W-1:0] ra,
   output logic            frame_start,
   output logic            firq_n
);

   localparam int c_DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int c_PIX_W = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(PIX_DIV - 1);
   localparam logic [c_PIX_W-1:0] c_PIX_LAST = c_PIX_W'(CHAR_W - 1);

   logic [4:0]      r_addr;
   logic [7:0]      r_r0, r_r1, r_r2, r_r3, r_r4, r_r6, r_r7, r_r9, r_r13;
   logic [5:0]      r_r12;
   logic [c_DIV_W-1:0] r_div;
   logic [c_PIX_W-1:0] r_pix;
   logic [7:0]      r_hc, r_row;
   logic [MA_W-1:0] r_ma_row;
   logic [4:0]      r_vs_cnt;

   logic [7:0]      w_hc_nxt, w_row_nxt;
   logic [RA_W-1:0] w_ra_nxt;
   logic [MA_W-1:0] w_ma_row_nxt;
   logic [4:0]      w_vs_cnt_nxt, w_vs_width;
   logic [8:0]      w_hs_end;
   logic            w_hc_wrap, w_ra_wrap, w_row_wrap, w_vs_start, w_hsync_nxt;

   assign ce_pix  = (r_div == c_DIV_LAST);
   assign ce_char = ce_pix && (r_pix == c_PIX_LAST);

   always_comb begin
      reg_dout = 8'h00;
      if (reg_rs && r_addr == 5'd12) reg_dout = {2'b00, r_r12};
      if (reg_rs && r_addr == 5'd13) reg_dout = r_r13;
   end

   // Wrap on >= so that shrinking a limit below the live count still wraps.
   always_comb begin
      w_hc_wrap    = (r_hc >= r_r0);
      w_ra_wrap    = w_hc_wrap && (8'(r_ra_q()) >= r_r9);
      w_row_wrap   = w_ra_wrap && (r_row >= r_r4);
      w_hc_nxt     = w_hc_wrap ? 8'd0 : r_hc + 8'd1;
      w_ra_nxt     = ra;
      w_row_nxt    = r_row;
      w_ma_row_nxt = r_ma_row;
      if (w_hc_wrap)
         w_ra_nxt = (8'(ra) >= r_r9) ? '0 : ra + RA_W'(1);
      if (w_ra_wrap) begin
         w_row_nxt    = w_row_wrap ? 8'd0 : r_row + 8'd1;
         w_ma_row_nxt = w_row_wrap ? MA_W'({r_r12, r_r13}) : r_ma_row + MA_W'(r_r1);
      end
      w_hs_end    = {1'b0, r_r2} + {5'b0_0000, r_r3[3:0]};
      w_hsync_nxt = (w_hc_nxt >= r_r2) && ({1'b0, w_hc_nxt} < w_hs_end);
      // vs_cnt holds the scanlines left in the pulse, including the current one.
      w_vs_width   = (r_r3[7:4] == 4'd0) ? 5'd16 : {1'b0, r_r3[7:4]};
      w_vs_start   = w_hc_wrap && (w_ra_nxt == '0) && (w_row_nxt == r_r7);
      w_vs_cnt_nxt = r_vs_cnt;
      if (w_vs_start)
         w_vs_cnt_nxt = w_vs_width;
      else if (w_hc_wrap && r_vs_cnt != 5'd0)
         w_vs_cnt_nxt = r_vs_cnt - 5'd1;
   end

   function automatic logic [RA_W-1:0] r_ra_q();
      return ra;
   endfunction

   always_ff @(posedge clk_20m or negedge reset_n) begin
      if (!reset_n) begin
         r_addr <= 5'd0;
         r_r0   <= R0_DEF;
         r_r1   <= R1_DEF;
         r_r2   <= R2_DEF;
         r_r3   <= R3_DEF;
         r_r4   <= R4_DEF;
         r_r6   <= R6_DEF;
         r_r7   <= R7_DEF;
         r_r9   <= R9_DEF;
         r_r12  <= R12_DEF[5:0];
         r_r13  <= R13_DEF;
      end else if (reg_cs && reg_we) begin
         if (!reg_rs) begin
            r_addr <= reg_din[4:0];
         end else begin
            case (r_addr)
               5'd0:    r_r0  <= reg_din;
               5'd1:    r_r1  <= reg_din;
               5'd2:    r_r2  <= reg_din;
               5'd3:    r_r3  <= reg_din;
               5'd4:    r_r4  <= reg_din;
               5'd6:    r_r6  <= reg_din;
               5'd7:    r_r7  <= reg_din;
               5'd9:    r_r9  <= reg_din;
               5'd12:   r_r12 <= reg_din[5:0];
               5'd13:   r_r13 <= reg_din;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_20m or negedge reset_n) begin
      if (!reset_n) begin
         r_div       <= '0;
         r_pix       <= '0;
         r_hc        <= 8'd0;
         r_row       <= 8'd0;
         r_ma_row    <= '0;
         r_vs_cnt    <= 5'd0;
         ra          <= '0;
         ma          <= '0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         hblank      <= 1'b1;
         vblank      <= 1'b1;
         de          <= 1'b0;
         frame_start <= 1'b0;
         firq_n      <= 1'b1;
      end else begin
         r_div       <= ce_pix ? '0 : r_div + c_DIV_W'(1);
         frame_start <= ce_char && w_row_wrap;
         if (ce_pix)
            r_pix <= (r_pix == c_PIX_LAST) ? '0 : r_pix + c_PIX_W'(1);
         if (ce_char) begin
            r_hc     <= w_hc_nxt;
            ra       <= w_ra_nxt;
            r_row    <= w_row_nxt;
            r_ma_row <= w_ma_row_nxt;
            r_vs_cnt <= w_vs_cnt_nxt;
            ma       <= w_ma_row_nxt + MA_W'(w_hc_nxt);
            hblank   <= (w_hc_nxt >= r_r1);
            vblank   <= (w_row_nxt >= r_r6);
            de       <= (w_hc_nxt < r_r1) && (w_row_nxt < r_r6);
            hsync    <= w_hsync_nxt;
            vsync    <= (w_vs_cnt_nxt != 5'd0);
         end
         // A new VSync edge outranks a simultaneous acknowledge.
         if (ce_char && w_vs_cnt_nxt != 5'd0 && !vsync)
            firq_n <= 1'b0;
         else if (firq_ack)
            firq_n <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qix_crtc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qix_crtc
//  Purpose  : Directed self-checking bench for qix_crtc.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qix_crtc;

   logic        clk_20m = 1'b0;
   logic        reset_n = 1'b0;
   logic        reg_cs = 1'b0, reg_rs = 1'b0, reg_we = 1'b0, firq_ack = 1'b0;
   logic [7:0]  reg_din = 8'h00;
   logic [7:0]  reg_dout;
   logic        ce_pix, ce_char, hsync, vsync, hblank, vblank, de, frame_start, firq_n;
   logic [13:0] ma;
   logic [4:0]  ra;

   int n_checks = 0;
   int n_fail   = 0;

   qix_crtc dut (
      .clk_20m(clk_20m), .reset_n(reset_n), .reg_cs(reg_cs), .reg_rs(reg_rs),
      .reg_we(reg_we), .reg_din(reg_din), .reg_dout(reg_dout), .firq_ack(firq_ack),
      .ce_pix(ce_pix), .ce_char(ce_char), .hsync(hsync), .vsync(vsync),
      .hblank(hblank), .vblank(vblank), .de(de), .ma(ma), .ra(ra),
      .frame_start(frame_start), .firq_n(firq_n)
   );

   always #5 clk_20m = ~clk_20m;

   task automatic tick();
      @(posedge clk_20m);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      reg_cs = 1'b0; reg_we = 1'b0; reg_rs = 1'b0; firq_ack = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
   endtask

   task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
      reg_cs = 1'b1; reg_we = 1'b1; reg_rs = 1'b0; reg_din = a;
      tick();
      reg_rs = 1'b1; reg_din = d;
      tick();
      reg_cs = 1'b0; reg_we = 1'b0;
   endtask

   task automatic reg_read(input logic [7:0] a, output logic [7:0] d);
      reg_cs = 1'b1; reg_we = 1'b1; reg_rs = 1'b0; reg_din = a;
      tick();
      reg_we = 1'b0; reg_rs = 1'b1;
      #1 d = reg_dout;
      reg_cs = 1'b0;
   endtask

   function automatic logic sig(input int w);
      case (w)
         0: return hsync;
         1: return vsync;
         2: return hblank;
         3: return de;
         4: return ce_pix;
         5: return ce_char;
         6: return frame_start;
         7: return vblank;
         8: return (ra == 5'd0);
         9: return (ma == 14'd30);
         default: return (ma == 14'd0);
      endcase
   endfunction

   // Ticks until sig(w)==lvl; n = -1 when the bound runs out.
   task automatic wait_level(input int w, input logic lvl, input int bound, output int n);
      n = 0;
      while (sig(w) !== lvl) begin
         if (n >= bound) begin
            n = -1;
            return;
         end
         tick();
         n++;
      end
   endtask

   task automatic wait_rise(input int w, input int bound, output int n);
      int a, b;
      wait_level(w, 1'b0, bound, a);
      wait_level(w, 1'b1, bound, b);
      n = (a < 0 || b < 0) ? -1 : a + b;
   endtask

   // 10 chars/line (320 clk), 2 lines/row, visible 8 chars x 2 rows, vsync at row 2.
   task automatic program_small(input logic [7:0] r3, input logic [7:0] r4);
      reg_write(8'd0, 8'd9);  reg_write(8'd1, 8'd8); reg_write(8'd2, 8'd4);
      reg_write(8'd3, r3);    reg_write(8'd4, r4);   reg_write(8'd6, 8'd2);
      reg_write(8'd7, 8'd2);  reg_write(8'd9, 8'd1);
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset_n = 1'b0;
      tick();
      n_checks++;
      if ({hsync, vsync, ce_pix, ce_char, frame_start} !== 5'b0) begin
         n_fail++; $display("FAIL reset_low_outs: got %b expected 00000", {hsync, vsync, ce_pix, ce_char, frame_start});
      end
      n_checks++;
      if ({hblank, vblank, de, firq_n} !== 4'b1101) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 1101", {hblank, vblank, de, firq_n});
      end
      n_checks++;
      if (ma !== 14'd0 || ra !== 5'd0) begin
         n_fail++; $display("FAIL reset_ma_ra: got ma=%0d ra=%0d expected 0 0", ma, ra);
      end
      do_reset();
      reg_read(8'd12, d);
      n_checks++;
      if (d !== 8'h00) begin
         n_fail++; $display("FAIL reset_r12: got %h expected 00", d);
      end
   endtask

   task automatic test_enables();
      int n;
      do_reset();
      wait_level(4, 1'b1, 50, n);
      n_checks++;
      if (n !== 3) begin
         n_fail++; $display("FAIL first_ce_pix: got %0d expected 3", n);
      end
      wait_rise(4, 50, n);
      n_checks++;
      if (n !== 4) begin
         n_fail++; $display("FAIL ce_pix_period: got %0d expected 4", n);
      end
      wait_rise(5, 100, n);
      wait_rise(5, 100, n);
      n_checks++;
      if (n !== 32 || ce_pix !== 1'b1) begin
         n_fail++; $display("FAIL ce_char_period: got %0d pix=%b expected 32 pix=1", n, ce_pix);
      end
   endtask

   task automatic test_default_timing();
      int w, l;
      do_reset();
      wait_rise(0, 3000, w);
      wait_level(0, 1'b0, 3000, w);
      wait_level(0, 1'b1, 3000, l);
      n_checks++;
      if (w !== 128) begin
         n_fail++; $display("FAIL hsync_width: got %0d expected 128", w);
      end
      n_checks++;
      if (w + l !== 1280 || w < 0 || l < 0) begin
         n_fail++; $display("FAIL hsync_period: got %0d expected 1280", w + l);
      end
      wait_rise(3, 3000, w);
      wait_level(3, 1'b0, 3000, w);
      n_checks++;
      if (w !== 1024) begin
         n_fail++; $display("FAIL de_width: got %0d expected 1024", w);
      end
      wait_level(8, 1'b0, 3000, w);
      wait_level(8, 1'b1, 12000, l);
      n_checks++;
      if (ma !== 14'd32 || l < 0 || hblank !== 1'b0) begin
         n_fail++; $display("FAIL ma_row1: got ma=%0d hblank=%b expected 32 0", ma, hblank);
      end
   endtask

   task automatic test_reg_access();
      logic [7:0] d;
      do_reset();
      reg_write(8'd12, 8'hFF);
      reg_read(8'd12, d);
      n_checks++;
      if (d !== 8'h3F) begin
         n_fail++; $display("FAIL r12_mask: got %h expected 3f", d);
      end
      reg_write(8'd13, 8'hA5);
      reg_read(8'd13, d);
      n_checks++;
      if (d !== 8'hA5) begin
         n_fail++; $display("FAIL r13_read: got %h expected a5", d);
      end
      reg_read(8'd0, d);
      n_checks++;
      if (d !== 8'h00) begin
         n_fail++; $display("FAIL r0_read: got %h expected 00", d);
      end
   endtask

   task automatic test_r0_shrink();
      int n;
      do_reset();
      wait_level(9, 1'b1, 2000, n);
      reg_write(8'd0, 8'd20);
      wait_level(5, 1'b1, 100, n);
      tick();
      n_checks++;
      if (ma !== 14'd0 || n < 0) begin
         n_fail++; $display("FAIL r0_wrap: got ma=%0d expected 0", ma);
      end
      wait_rise(10, 2000, n);
      n_checks++;
      if (n !== 672) begin
         n_fail++; $display("FAIL r0_line_period: got %0d expected 672", n);
      end
   endtask

   task automatic test_vsync_firq();
      int w, l;
      do_reset();
      program_small(8'h41, 8'd3);
      wait_rise(1, 6000, w);
      n_checks++;
      if (firq_n !== 1'b0 || w < 0) begin
         n_fail++; $display("FAIL firq_set: got %b expected 0", firq_n);
      end
      wait_level(1, 1'b0, 6000, w);
      n_checks++;
      if (w !== 1280 || firq_n !== 1'b0) begin
         n_fail++; $display("FAIL vsync_width_held: got %0d firq_n=%b expected 1280 0", w, firq_n);
      end
      firq_ack = 1'b1; tick(); firq_ack = 1'b0;
      n_checks++;
      if (firq_n !== 1'b1) begin
         n_fail++; $display("FAIL firq_ack: got %b expected 1", firq_n);
      end
      wait_level(1, 1'b1, 6000, l);
      n_checks++;
      if (w + l + 1 !== 2560 || firq_n !== 1'b0) begin
         n_fail++; $display("FAIL vsync_period: got %0d firq_n=%b expected 2560 0", w + l + 1, firq_n);
      end
      firq_ack = 1'b1; tick(); firq_ack = 1'b0;
      n_checks++;
      if (firq_n !== 1'b1) begin
         n_fail++; $display("FAIL firq_ack2: got %b expected 1", firq_n);
      end
      repeat (2558) tick();
      firq_ack = 1'b1; tick(); firq_ack = 1'b0;
      n_checks++;
      if (vsync !== 1'b1 || firq_n !== 1'b0) begin
         n_fail++; $display("FAIL firq_set_wins: got vsync=%b firq_n=%b expected 1 0", vsync, firq_n);
      end
   endtask

   task automatic test_frame_ma();
      int n;
      do_reset();
      program_small(8'h41, 8'd3);
      reg_write(8'd12, 8'h01);
      reg_write(8'd13, 8'h00);
      wait_rise(7, 3000, n);
      n_checks++;
      if (ma !== 14'd16 || n < 0) begin
         n_fail++; $display("FAIL ma_same_frame: got %0d expected 16", ma);
      end
      wait_rise(6, 3000, n);
      n_checks++;
      if (ma !== 14'h100 || ra !== 5'd0 || n < 0) begin
         n_fail++; $display("FAIL ma_frame_start: got ma=%h ra=%0d expected 100 0", ma, ra);
      end
      wait_level(8, 1'b0, 1000, n);
      wait_level(8, 1'b1, 1000, n);
      n_checks++;
      if (ma !== 14'h108 || n < 0) begin
         n_fail++; $display("FAIL ma_next_row: got %h expected 108", ma);
      end
   endtask

   task automatic test_r3_zero();
      int n, hs;
      do_reset();
      program_small(8'h00, 8'd11);
      hs = 0;
      repeat (400) begin
         tick();
         if (hsync) hs++;
      end
      n_checks++;
      if (hs !== 0) begin
         n_fail++; $display("FAIL hsync_disabled: got %0d high clks expected 0", hs);
      end
      wait_rise(1, 10000, n);
      wait_level(1, 1'b0, 10000, n);
      n_checks++;
      if (n !== 5120) begin
         n_fail++; $display("FAIL vsync_16_lines: got %0d expected 5120", n);
      end
   endtask

   task automatic test_async_reset();
      int n;
      do_reset();
      repeat (100) tick();
      n_checks++;
      if (de !== 1'b1) begin
         n_fail++; $display("FAIL de_before_reset: got %b expected 1", de);
      end
      #3 reset_n = 1'b0;
      #1;
      n_checks++;
      if (de !== 1'b0 || hblank !== 1'b1 || ma !== 14'd0 || ra !== 5'd0) begin
         n_fail++; $display("FAIL async_reset: got de=%b hblank=%b ma=%0d ra=%0d expected 0 1 0 0", de, hblank, ma, ra);
      end
      #2 reset_n = 1'b1;
      n = 0;
      while (n < 100) begin
         tick();
         n++;
         if (ce_char) break;
      end
      // ce_char is high through the clock period that ends on edge n+1.
      n_checks++;
      if (n + 1 !== 32) begin
         n_fail++; $display("FAIL first_ce_char: got %0d expected 32", n + 1);
      end
   endtask

   initial begin
      test_reset();
      test_enables();
      test_default_timing();
      test_reg_access();
      test_r0_shrink();
      test_vsync_firq();
      test_frame_ma();
      test_r3_zero();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
